// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the multi-cycle adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nb_chunks(input int n_bits, input int c_bits);
        return n_bits / c_bits;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational ripple-carry slice adder; also exposes the carry entering its MSB
// so the parent can derive signed overflow on the top slice.
module adder_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout,
    output logic         o_cmsb
);

    // Each bit owns its carry nets so the chain is a plain ripple of distinct signals.
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        logic w_cin;
        logic w_co;

        if (gi == 0) begin : g_first
            assign w_cin = i_cin;
        end else begin : g_chain
            assign w_cin = g_bit[gi-1].w_co;
        end

        assign o_sum[gi] = i_a[gi] ^ i_b[gi] ^ w_cin;
        assign w_co      = (i_a[gi] & i_b[gi]) | (w_cin & (i_a[gi] ^ i_b[gi]));
    end

    assign o_cout = g_bit[W-1].w_co;
    assign o_cmsb = g_bit[W-1].w_cin;

endmodule

// File: rtl/addsub_multicycle.sv
// Handshaked adder/subtractor that processes one chunk_bits slice per clock,
// least-significant slice first, reusing a single slice adder.
module addsub_multicycle
    import addsub_pkg::*;
#(
    parameter int nb_bits    = 32,
    parameter int chunk_bits = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               sub_i,
    input  logic [nb_bits-1:0] a_i,
    input  logic [nb_bits-1:0] b_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [nb_bits:0]   sum_o,
    output logic               ovf_o
);

    localparam int NB_CHUNKS = calc_nb_chunks(nb_bits, chunk_bits);
    localparam int CW        = $clog2(NB_CHUNKS + 1);
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NB_CHUNKS - 1);

    if ((nb_bits < 1) || (chunk_bits < 1) || ((nb_bits % chunk_bits) != 0)) begin : g_bad_param
        $error("addsub_multicycle: nb_bits must be a positive multiple of chunk_bits");
    end

    state_t              r_state;
    state_t              w_state_next;
    logic [CW-1:0]       r_cnt;
    logic [nb_bits-1:0]  r_a;
    logic [nb_bits-1:0]  r_b;
    logic [nb_bits-1:0]  r_sum_lo;
    logic                r_carry;
    logic                r_cout;
    logic                r_ovf;

    logic                w_accept;
    logic                w_last;
    logic [chunk_bits-1:0] w_chunk_sum;
    logic                w_chunk_cout;
    logic                w_chunk_cmsb;
    logic [nb_bits-1:0]  w_sum_lo_next;

    assign ready_o  = rst_ni && (r_state == IDLE);
    assign valid_o  = (r_state == DONE);
    assign w_accept = valid_i && ready_o;
    assign w_last   = (r_cnt == LAST_CHUNK);

    assign sum_o = {r_cout, r_sum_lo};
    assign ovf_o = r_ovf;

    adder_chunk #(
        .W(chunk_bits)
    ) u_adder (
        .i_a    (r_a[chunk_bits-1:0]),
        .i_b    (r_b[chunk_bits-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_chunk_sum),
        .o_cout (w_chunk_cout),
        .o_cmsb (w_chunk_cmsb)
    );

    // New slices enter at the top, so after the last slice every one sits in place.
    if (NB_CHUNKS == 1) begin : g_single
        assign w_sum_lo_next = w_chunk_sum;
    end else begin : g_multi
        assign w_sum_lo_next = {w_chunk_sum, r_sum_lo[nb_bits-1:chunk_bits]};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = BUSY;
            BUSY:    if (w_last)   w_state_next = DONE;
            DONE:    if (ready_i)  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sum_lo <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Subtraction is a + ~b + 1: invert B once and seed the carry.
                    if (w_accept) begin
                        r_a     <= a_i;
                        r_b     <= b_i ^ {nb_bits{sub_i}};
                        r_carry <= sub_i;
                        r_cnt   <= '0;
                    end
                end
                BUSY: begin
                    r_a      <= r_a >> chunk_bits;
                    r_b      <= r_b >> chunk_bits;
                    r_carry  <= w_chunk_cout;
                    r_sum_lo <= w_sum_lo_next;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cout <= w_chunk_cout;
                        r_ovf  <= w_chunk_cmsb ^ w_chunk_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
